// File: rtl/noc_packet_injector.sv
// Simulation-side NoC packet injector: one command produces one OpTiMSoC packet on one vchannel.
// Optional trailing XOR checksum flit when NOC_INJECTOR_CHECKSUM_EN is defined.
module noc_packet_injector #(
    parameter int unsigned FLIT_WIDTH = 34,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned SRC_ID     = 0,
    parameter int unsigned MAX_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4:0]            cmd_dest,
    input  logic [2:0]            cmd_class,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_vch,
    input  logic [31:0]           cmd_seed,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic [CHANNELS-1:0]   out_valid,
    input  logic [CHANNELS-1:0]   out_ready,
    output logic                  busy,
    output logic [31:0]           pkt_count,
    output logic [31:0]           stall_count
);

`ifdef NOC_INJECTOR_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HEAD, PAY, CSUM} state_t;
    localparam bit CSUM_EN = 1'b1;
`else
    typedef enum logic [1:0] {IDLE, HEAD, PAY} state_t;
    localparam bit CSUM_EN = 1'b0;
`endif

    state_t                state, state_d;
    logic [FLIT_WIDTH-1:0] flit_d;
    logic [CHANNELS-1:0]   valid_d;
    logic [31:0]           data, data_d;
    logic [7:0]            rem, rem_d;
    logic [31:0]           pkt_d, stall_d;
    logic [7:0]            len_c;
    logic [2:0]            vch_sel;
    logic                  hs;
    logic                  done;
`ifdef NOC_INJECTOR_CHECKSUM_EN
    logic [31:0]           csum, csum_d;
`endif

    function automatic logic [CHANNELS-1:0] vch_onehot(input logic [2:0] c);
        logic [CHANNELS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) v[i] = (32'(c) == i);
        return v;
    endfunction

    // Only the selected channel's valid bit is ever set, so this masks out foreign ready bits.
    assign hs      = |(out_valid & out_ready);
    assign len_c   = (32'(cmd_len) > MAX_LEN) ? 8'(MAX_LEN) : cmd_len;
    assign vch_sel = (32'(cmd_vch) < CHANNELS) ? cmd_vch : 3'd0;

    always_comb begin
        state_d = state;
        flit_d  = out_flit;
        valid_d = out_valid;
        data_d  = data;
        rem_d   = rem;
        pkt_d   = pkt_count;
        stall_d = stall_count;
        done    = 1'b0;
`ifdef NOC_INJECTOR_CHECKSUM_EN
        csum_d  = csum;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    flit_d        = '0;
                    flit_d[33]    = (len_c == 8'd0) && !CSUM_EN;
                    flit_d[32]    = 1'b1;
                    flit_d[31:0]  = {cmd_dest, cmd_class, 5'(SRC_ID), pkt_count[18:0]};
                    valid_d       = vch_onehot(vch_sel);
                    data_d        = cmd_seed;
                    rem_d         = len_c;
                    state_d       = HEAD;
`ifdef NOC_INJECTOR_CHECKSUM_EN
                    csum_d        = '0;
`endif
                end
            end
            HEAD, PAY: begin
                if (hs) begin
`ifdef NOC_INJECTOR_CHECKSUM_EN
                    csum_d = csum ^ out_flit[31:0];
`endif
                    if (rem != 8'd0) begin
                        flit_d       = '0;
                        flit_d[33]   = (rem == 8'd1) && !CSUM_EN;
                        flit_d[31:0] = data;
                        data_d       = data + 32'd1;
                        rem_d        = rem - 8'd1;
                        state_d      = PAY;
                    end else begin
`ifdef NOC_INJECTOR_CHECKSUM_EN
                        flit_d       = '0;
                        flit_d[33]   = 1'b1;
                        flit_d[31:0] = csum ^ out_flit[31:0];
                        state_d      = CSUM;
`else
                        done         = 1'b1;
`endif
                    end
                end
            end
`ifdef NOC_INJECTOR_CHECKSUM_EN
            CSUM: if (hs) done = 1'b1;
`endif
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = IDLE;
            flit_d  = '0;
            valid_d = '0;
            pkt_d   = pkt_count + 32'd1;
        end
        if ((|out_valid) && !hs && (stall_count != '1)) stall_d = stall_count + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_flit    <= '0;
            out_valid   <= '0;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            pkt_count   <= '0;
            stall_count <= '0;
            data        <= '0;
            rem         <= '0;
`ifdef NOC_INJECTOR_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            state       <= state_d;
            out_flit    <= flit_d;
            out_valid   <= valid_d;
            cmd_ready   <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            pkt_count   <= pkt_d;
            stall_count <= stall_d;
            data        <= data_d;
            rem         <= rem_d;
`ifdef NOC_INJECTOR_CHECKSUM_EN
            csum        <= csum_d;
`endif
        end
    end

endmodule

// File: doc/noc_packet_injector.md
# noc_packet_injector

Simulation-side NoC packet transmitter that drives one tile link (flit, per-vchannel valid/ready) with well-formed OpTiMSoC packets on command. It is the sending counterpart to the NoC link monitors and tracers in the system testbenches. It lets a bench inject directed traffic into a router port or network adapter of a `system_*` instance without running software on a compute tile. Each command produces exactly one packet on one virtual channel. Status counters are exported for bench checks.

## Interface
- `FLIT_WIDTH`, 34: flit width; [33] last, [32] first, [31:0] data.
- `CHANNELS`, 1: number of virtual channels on the link (1..8).
- `SRC_ID`, 0: 5-bit source tile id placed in header bits [23:19].
- `MAX_LEN`, 16: maximum payload flits per packet (1..255).

Ports:
- `clk`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_dest`  in  5  destination tile, header [31:27].
- `cmd_class`  in  3  message class, header [26:24].
- `cmd_len`  in  8  payload flit count; 0 gives a header-only packet.
- `cmd_vch`  in  3  target virtual channel.
- `cmd_seed`  in  32  first payload word.
- `out_flit`  out  FLIT_WIDTH  flit; shared by all vchannels.
- `out_valid`  out  CHANNELS  one-hot valid; at most one bit set.
- `out_ready`  in  CHANNELS  per-vchannel ready from the link.
- `busy`  out  1  packet in progress; high outside IDLE.
- `pkt_count`  out  32  completed packets; wraps.
- `stall_count`  out  32  cycles with valid set and ready low; saturates.

## Operation
- FSM states: IDLE, HEAD, PAY, and CSUM (CSUM only with the macro defined).
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch dest, class, vch, seed, and `len = min(cmd_len, MAX_LEN)`, then go to HEAD.
- Channel select: if `cmd_vch >= CHANNELS`, channel 0 is used.
- HEAD: drive the header flit:
  - [31:27]=dest, [26:24]=class, [23:19]=SRC_ID.
  - [18:0]=`pkt_count[18:0]`.
  - [32]=1.
  - [33]=1 only if this is the sole flit.
- PAY: payload flit i (0-based) carries `seed + i`, computed mod 2^32.
  - [32]=0.
  - [33]=1 on the final flit of the packet.
- Advancing:
  - A flit advances only on `out_valid[ch] & out_ready[ch]`.
  - Flit and valid hold stable while stalled.
  - After the handshake on the final flit, go to IDLE and increment `pkt_count`.
- Data bits [31:0] in IDLE are don't-care, but are driven to 0.
- `stall_count` increments in any cycle where `|out_valid` is high and `out_ready[ch]` is low. It saturates at 32'hFFFF_FFFF.
- `out_ready` bits for channels other than `ch` are ignored.

## Timing
- All outputs are registered.
- Reset values: `out_valid`=0, `out_flit`=0, `cmd_ready`=0 during reset (1 in the first cycle after), `busy`=0, both counters 0.
- Command accepted at edge N: header valid from cycle N+1. With `out_ready` held high, the final flit handshakes at cycle N+1+len.
- Packet-to-packet: one IDLE cycle minimum; `cmd_ready` is high the cycle after the last handshake. This gives 1 bubble.
- `cmd_*` inputs are ignored while not in IDLE.
- `rst` mid-packet: the next edge drops `out_valid`, abandons the partial packet (no `last` is sent), and clears the counters.
- A stall and a reset in the same cycle: reset wins and the counter ends at 0.

## Configuration
- `NOC_INJECTOR_CHECKSUM_EN` defined:
  - After the payload, a CSUM flit carries the XOR of the [31:0] of all prior flits of the packet, header included.
  - CSUM is the `last` flit; payload flits then have [33]=0.
  - Packet length is len+2 flits.
  - `cmd_len`=0 gives a 2-flit packet: header, then a checksum equal to the header.
- Not defined: the CSUM state and XOR register are absent, and the packet is len+1 flits.

## Test plan
- Basic packet (no macro): reset, dest=3, class=2, len=2, seed=0x100, ready=1.
  - Required flits: 0x1A00_0000 {first}, 0x100, 0x101 {last}, at cycles N+1..N+3.
  - Then `pkt_count`=1.
- Header-only: len=0.
  - Single flit with [32] and [33] both set.
  - `cmd_ready` back at N+2.
- Backpressure:
  - Stimulus: len=3, ready low for 5 cycles on the second flit.
  - Required: flit stable throughout, `stall_count`=5, payload order unchanged.
- Channel and clamp: CHANNELS=2, vch=1, len=40, MAX_LEN=16.
  - Only `out_valid[1]` toggles, and 17 flits are sent.
  - vch=5 routes to channel 0.
- Reset mid-packet: assert `rst` during the second payload flit.
  - Next cycle `out_valid`=0 and the counters are 0.
  - A new command then produces a header with [18:0]=0.
- Checksum (macro defined): dest=1, class=0, SRC_ID=2, len=1, seed=0xFFFF_FFFF.
  - Third flit = 0x0810_0000 ^ 0xFFFF_FFFF = 0xF7EF_FFFF, with [33] set.
